spike_raster_fb: RTL and testbench

//  Parametrised spike-to-framebuffer rasteriser: accumulates per-neuron spike intensity into an internal

---
 rtl/spike_raster_fb.sv | 209 ++++++++++++++++++++
 tb/tb_spike_raster_fb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_raster_fb.sv
// spike_raster_fb: spike-to-framebuffer rasteriser.
// Accumulates per-neuron spike intensity into an internal GRID_W*GRID_H pixel
// store (saturating add), mirrors every internal write onto fb_we/fb_addr/fb_data
// and serves a registered read port. Spikes are absorbed by a small FIFO.
// Define SPIKE_RASTER_DECAY_EN to build the per-frame decay sweep; without it a
// frame_tick only echoes frame_done and pixels are cleared solely by reset.
module spike_raster_fb #(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int IDX_WIDTH   = 16,
    parameter int PIX_WIDTH   = 8,
    parameter int INC         = 32,
    parameter int DECAY_SHIFT = 1,
    parameter int FIFO_DEPTH  = 4,
    localparam int N          = GRID_W * GRID_H,
    localparam int AW         = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spike_valid,
    input  logic [IDX_WIDTH-1:0] spike_idx,
    input  logic                 frame_tick,
    input  logic [AW-1:0]        rd_addr,
    output logic [PIX_WIDTH-1:0] rd_data,
    output logic                 fb_we,
    output logic [AW-1:0]        fb_addr,
    output logic [PIX_WIDTH-1:0] fb_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 oor,
    output logic [15:0]          drop_count
);
`ifdef SPIKE_RASTER_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif
    localparam int                   FW     = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]        LAST   = AW'(N - 1);
    localparam logic [IDX_WIDTH:0]   N_IDX  = N[IDX_WIDTH:0];
    localparam logic [PIX_WIDTH:0]   INC_W  = INC[PIX_WIDTH:0];
    localparam logic [AW-1:0]        ONE_A  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [FW:0]          ONE_P  = {{FW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {CLEAR, IDLE, SRD, SWR, DRD, DWR} state_t;

    // One internal write port; the fb mirror is this port made visible.
    typedef struct packed {
        logic                 en;
        logic [AW-1:0]        addr;
        logic [PIX_WIDTH-1:0] data;
    } wr_t;

    state_t               state;
    logic [AW-1:0]        ctr;
    logic [AW-1:0]        sp_addr;
    logic [PIX_WIDTH-1:0] pix_q;
    logic                 tick_pend;
    logic [PIX_WIDTH-1:0] mem [N];
    logic [AW-1:0]        fifo_mem [FIFO_DEPTH];
    logic [FW:0]          wr_ptr, rd_ptr;
    wr_t                  wr;

    logic                 in_range, spike_ok, fifo_empty, fifo_full;
    logic                 tick_now, can_take, take_fifo, take_bypass, push, drop;
    logic [PIX_WIDTH:0]   sum;

    assign in_range   = {1'b0, spike_idx} < N_IDX;
    assign spike_ok   = spike_valid && in_range;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
    // A tick (pending or arriving now) beats queued spikes when the FSM is free.
    assign tick_now   = DECAY_EN && (tick_pend || frame_tick);
    // SWR doubles as an idle slot so back-to-back spikes run at 2 clk each.
    assign can_take   = (state == IDLE || state == SWR) && !tick_now;
    assign take_fifo  = can_take && !fifo_empty;
    // Empty FIFO: the incoming spike goes straight to SRD, keeping write latency at 2.
    assign take_bypass = can_take && fifo_empty && spike_ok;
    // Full is judged before any same-cycle pop, so a pop frees no slot this cycle.
    assign push       = spike_ok && !take_bypass && !fifo_full;
    assign drop       = spike_valid && (!in_range || fifo_full);
    assign sum        = {1'b0, pix_q} + INC_W;

    // Decode the single write port from the current state.
    always_comb begin
        wr = '0;
        case (state)
            CLEAR: begin
                wr.en   = 1'b1;
                wr.addr = ctr;
            end
            SWR: begin
                wr.en   = 1'b1;
                wr.addr = sp_addr;
                wr.data = sum[PIX_WIDTH] ? '1 : sum[PIX_WIDTH-1:0];
            end
            DWR: begin
                wr.en   = 1'b1;
                wr.addr = ctr;
                wr.data = pix_q >> DECAY_SHIFT;
            end
            default: ;
        endcase
        if (reset) wr.en = 1'b0;
    end

    assign fb_we   = wr.en;
    assign fb_addr = wr.addr;
    assign fb_data = wr.data;

    // Pixel store write.
    always_ff @(posedge clk) begin
        if (wr.en) mem[wr.addr] <= wr.data;
    end

    // Host read port; a same-edge write is not forwarded.
    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_addr];
    end

    // Spike FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + ONE_P;
            if (take_fifo) rd_ptr <= rd_ptr + ONE_P;
        end
    end

    // Spike FIFO storage.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FW-1:0]] <= spike_idx[AW-1:0];
    end

    // Control FSM with status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            ctr        <= '0;
            sp_addr    <= '0;
            pix_q      <= '0;
            tick_pend  <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            oor        <= 1'b0;
            drop_count <= '0;
        end else begin
            frame_done <= DECAY_EN ? 1'b0 : frame_tick;
            if (spike_valid && !in_range)            oor      <= 1'b1;
            if (spike_ok && fifo_full)               overflow <= 1'b1;
            if (drop && drop_count != 16'hFFFF)      drop_count <= drop_count + 16'd1;
            // Ticks during a sweep merge into it.
            if (DECAY_EN && frame_tick && state != DRD && state != DWR) tick_pend <= 1'b1;
            case (state)
                CLEAR: begin
                    if (ctr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ctr   <= '0;
                    end else begin
                        ctr <= ctr + ONE_A;
                    end
                end
                IDLE, SWR: begin
                    if (tick_now) begin
                        state     <= DRD;
                        busy      <= 1'b1;
                        ctr       <= '0;
                        tick_pend <= 1'b0;
                    end else if (take_fifo) begin
                        sp_addr <= fifo_mem[rd_ptr[FW-1:0]];
                        state   <= SRD;
                    end else if (take_bypass) begin
                        sp_addr <= spike_idx[AW-1:0];
                        state   <= SRD;
                    end else begin
                        state <= IDLE;
                    end
                end
                SRD: begin
                    pix_q <= mem[sp_addr];
                    state <= SWR;
                end
                DRD: begin
                    pix_q <= mem[ctr];
                    state <= DWR;
                end
                DWR: begin
                    if (ctr == LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        ctr        <= '0;
                    end else begin
                        ctr   <= ctr + ONE_A;
                        state <= DRD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_raster_fb.sv
// Directed bench for spike_raster_fb (defaults, N=256). Expectations for the
// decay build are selected when SPIKE_RASTER_DECAY_EN is defined.
module tb_spike_raster_fb;
`ifdef SPIKE_RASTER_DECAY_EN
    localparam bit DECAY = 1'b1;
`else
    localparam bit DECAY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spike_valid = 1'b0;
    logic [15:0] spike_idx = '0;
    logic        frame_tick = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        fb_we;
    logic [7:0]  fb_addr;
    logic [7:0]  fb_data;
    logic        busy, frame_done, overflow, oor;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    spike_raster_fb dut (
        .clk(clk), .reset(reset), .spike_valid(spike_valid), .spike_idx(spike_idx),
        .frame_tick(frame_tick), .rd_addr(rd_addr), .rd_data(rd_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy),
        .frame_done(frame_done), .overflow(overflow), .oor(oor), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        rd_addr = a;
        step(1);
        d = rd_data;
    endtask

    // Step until busy drops or the budget runs out; count mirror writes and done pulses.
    task automatic run_busy(input int limit, output int n, output int we, output int fd);
        n = 0; we = 0; fd = 0;
        while (busy === 1'b1 && n < limit) begin
            if (fb_we === 1'b1) we++;
            if (frame_done === 1'b1) fd++;
            step(1);
            n++;
        end
    endtask

    initial begin
        logic [7:0] d;
        int n, we, fd, seen;
        int exp3 [9] = '{32, 64, 96, 128, 160, 192, 224, 255, 255};

        // 1: reset state, then a 256-cycle CLEAR with no frame_done
        step(2);
        chk("rst_busy", busy, 1);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_oor", oor, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        #1;
        run_busy(1000, n, we, fd);
        chk("clear_cycles", n, 256);
        chk("clear_writes", we, 256);
        chk("clear_no_done", fd, 0);
        rd(8'd0, d);   chk("clear_pix0", d, 0);
        rd(8'd255, d); chk("clear_pix255", d, 0);

        // 2: single spike, write visible two cycles after the strobe cycle
        spike_valid = 1'b1; spike_idx = 16'd5;
        step(1);
        spike_valid = 1'b0;
        chk("lat_t1_we", fb_we, 0);
        step(1);
        chk("lat_t2_we", fb_we, 1);
        chk("lat_t2_addr", fb_addr, 5);
        chk("lat_t2_data", fb_data, 32);
        rd_addr = 8'd5;
        step(1);
        chk("rd_same_edge_old", rd_data, 0);
        step(1);
        chk("rd_pix5", rd_data, 32);

        // 3: nine spikes on idx 7 every 2 clk, saturating at 255
        for (int i = 0; i < 9; i++) begin
            spike_valid = 1'b1; spike_idx = 16'd7;
            step(1);
            spike_valid = 1'b0;
            step(1);
            chk($sformatf("sat_we_%0d", i), fb_we, 1);
            chk($sformatf("sat_data_%0d", i), fb_data, exp3[i]);
        end
        step(1);
        rd(8'd7, d); chk("sat_pix7", d, 255);

        // 4: frame tick
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        if (DECAY) begin
            run_busy(2000, n, we, fd);
            chk("decay_cycles", n, 512);
            chk("decay_no_early_done", fd, 0);
            chk("decay_done", frame_done, 1);
            step(1);
            chk("decay_done_pulse", frame_done, 0);
            rd(8'd7, d); chk("decay_pix7", d, 127);
            rd(8'd5, d); chk("decay_pix5", d, 16);
        end else begin
            chk("tick_done", frame_done, 1);
            chk("tick_not_busy", busy, 0);
            chk("tick_no_write", fb_we, 0);
            step(1);
            chk("tick_done_pulse", frame_done, 0);
            rd(8'd7, d); chk("tick_pix7", d, 255);
            rd(8'd5, d); chk("tick_pix5", d, 32);
        end

        // 5 (decay): six back-to-back spikes during a sweep; FIFO of 4 drops two
        if (DECAY) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(9);
            spike_valid = 1'b1; spike_idx = 16'd9;
            step(6);
            spike_valid = 1'b0;
            chk("sweep_overflow", overflow, 1);
            chk("sweep_drops", drop_count, 2);
            run_busy(2000, n, we, fd);
            chk("sweep2_done", frame_done, 1);
            step(12);
            rd(8'd9, d); chk("sweep_pix9", d, 128);
            rd(8'd7, d); chk("sweep_pix7", d, 63);
        end

        // 6: out-of-range spike is dropped without a write
        spike_valid = 1'b1; spike_idx = 16'd300;
        step(1);
        spike_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (fb_we === 1'b1) seen++;
            step(1);
        end
        chk("oor_no_write", seen, 0);
        chk("oor_flag", oor, 1);
        chk("oor_drops", drop_count, DECAY ? 3 : 1);

        // Reset mid-operation clears flags and restarts CLEAR
        if (DECAY) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(20);
        end
        reset = 1'b1;
        step(1);
        chk("rst2_busy", busy, 1);
        chk("rst2_oor", oor, 0);
        chk("rst2_overflow", overflow, 0);
        chk("rst2_drops", drop_count, 0);
        chk("rst2_fb_we", fb_we, 0);
        reset = 1'b0;
        // Spikes arriving during CLEAR queue; depth 4 keeps four, drops two
        spike_valid = 1'b1; spike_idx = 16'd9;
        step(6);
        spike_valid = 1'b0;
        chk("clr_overflow", overflow, 1);
        chk("clr_drops", drop_count, 2);
        run_busy(1000, n, we, fd);
        chk("clr2_cycles", n, 250);
        chk("clr2_no_done", fd, 0);
        step(12);
        rd(8'd9, d); chk("clr_pix9", d, 128);
        rd(8'd7, d); chk("clr_pix7", d, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
